dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_responder.sv | 127 ++++++++++++
 tb/tb_dmem_responder.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Single-outstanding 64-bit word memory: accepts one request, replies with the old word LATENCY cycles later.
// Backpressure: req_ready low while a transaction is in flight; the response is held until resp_ready or flush.
module dmem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [63:0] req_addr,
  input  logic [7:0]  req_we,
  input  logic [63:0] req_wdata,
  input  logic        req_flush,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = (LATENCY > 2) ? $clog2(LATENCY - 1) : 1;
  localparam logic [CW-1:0] CNT_INIT = CW'((LATENCY > 1) ? (LATENCY - 2) : 0);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [63:0]     rdata_q, rdata_d;
  logic            err_q, err_d;
  logic [63:0]     mem_q [DEPTH];

  logic [AW-1:0]   idx;
  logic            oor;
  logic            accept;
  logic            wr_en;
  logic            unused_addr_bits;

  assign idx              = req_addr[AW+2:3];
  assign oor              = |req_addr[63:AW+3];
  assign req_ready        = (state_q == IDLE) && !req_flush;
  assign accept           = req_valid && req_ready;
  assign wr_en            = accept && !oor;
  assign unused_addr_bits = ^req_addr[2:0];

  assign resp_valid = (state_q == RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          // Read-before-write: the response carries the word as it was before this request's strobes land.
          rdata_d = oor ? 64'd0 : mem_q[idx];
          err_d   = oor;
          if (LATENCY == 1) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (req_flush) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == '0) begin
          state_d = RESP;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      RESP: begin
        if (req_flush || resp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  // Array is deliberately outside the reset domain so committed writes survive reset and flush.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int i = 0; i < 8; i++) begin
        if (req_we[i]) begin
          mem_q[idx][8*i +: 8] <= req_wdata[8*i +: 8];
        end
      end
    end
  end

  a_state_legal : assert property (@(posedge clk) disable iff (!rst)
    state_q inside {IDLE, WAIT, RESP});

  a_resp_stable : assert property (@(posedge clk) disable iff (!rst)
    (resp_valid && !resp_ready && !req_flush) |=>
      (resp_valid && $stable(resp_rdata) && $stable(resp_err)));

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed scenarios plus randomized traffic scored against a word-array model.
module tb_dmem_responder;

  localparam int DEPTH = 1024;
  localparam int LAT   = 2;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [63:0] req_addr;
  logic [7:0]  req_we;
  logic [63:0] req_wdata;
  logic        req_flush;
  logic        resp_valid;
  logic        resp_ready;
  logic [63:0] resp_rdata;
  logic        resp_err;

  int n_cmp = 0;
  int n_bad = 0;

  // Model covers words 0..15, which is where the randomized traffic lands.
  logic [63:0] mdl [16];
  bit          known [16];

  dmem_responder #(.DEPTH(DEPTH), .LATENCY(LAT)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_addr   (req_addr),
    .req_we     (req_we),
    .req_wdata  (req_wdata),
    .req_flush  (req_flush),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] wd, input logic [7:0] we);
    logic [63:0] r;
    r = old;
    for (int i = 0; i < 8; i++) if (we[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  // Drives one request and reports what was observed; callers decide what is correct.
  task automatic run_req(input logic [63:0] a, input logic [7:0] we, input logic [63:0] wd,
                         input int stall, input int fmode,
                         output int lat, output logic [63:0] rd, output logic er,
                         output bit held_ok, output bit post_ok);
    int n;
    lat = -1; rd = '0; er = 1'b0; held_ok = 1'b1; post_ok = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_addr = a; req_we = we; req_wdata = wd;
    #1;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk); #1; n++;
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
    req_addr  = {$urandom, $urandom};
    req_we    = 8'($urandom);
    req_wdata = {$urandom, $urandom};
    @(negedge clk);
    n = 1;
    if (fmode == 1) begin
      req_flush = 1'b1;
      @(negedge clk);
      req_flush = 1'b0;
      #1;
      post_ok = !resp_valid && (req_ready === 1'b1);
      repeat (3) begin
        @(negedge clk);
        if (resp_valid !== 1'b0) post_ok = 1'b0;
      end
      return;
    end
    while (!resp_valid && n < 20) begin
      @(negedge clk); n++;
    end
    if (!resp_valid) return;
    lat = n; rd = resp_rdata; er = resp_err;
    if (fmode == 2) begin
      req_flush = 1'b1; resp_ready = 1'b1;
      @(negedge clk);
      req_flush = 1'b0; resp_ready = 1'b0;
      #1;
      post_ok = !resp_valid && (req_ready === 1'b1);
      return;
    end
    for (int s = 0; s < stall; s++) begin
      if (resp_valid !== 1'b1 || resp_rdata !== rd || resp_err !== er || req_ready !== 1'b0) held_ok = 1'b0;
      @(negedge clk);
    end
    if (resp_valid !== 1'b1 || resp_rdata !== rd || resp_err !== er || req_ready !== 1'b0) held_ok = 1'b0;
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    #1;
    post_ok = !resp_valid && (req_ready === 1'b1);
  endtask

  task automatic test_reset;
    #1;
    n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", resp_valid); end
    n_cmp++; if (resp_rdata !== 64'd0) begin n_bad++; $display("FAIL reset_rdata: got %h want 0", resp_rdata); end
    n_cmp++; if (resp_err !== 1'b0) begin n_bad++; $display("FAIL reset_err: got %b want 0", resp_err); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready: got %b want 1", req_ready); end
  endtask

  task automatic test_init;
    int lat; logic [63:0] rd, v; logic er; bit h, p;
    for (int i = 0; i < 16; i++) begin
      v = {$urandom, $urandom};
      run_req(64'(i) << 3, 8'hFF, v, 0, 0, lat, rd, er, h, p);
      mdl[i] = v; known[i] = 1'b1;
      n_cmp++; if (lat !== LAT) begin n_bad++; $display("FAIL init_lat[%0d]: got %0d want %0d", i, lat, LAT); end
    end
  endtask

  task automatic test_rw;
    int lat; logic [63:0] rd; logic er; bit h, p;
    run_req(64'h10, 8'hFF, 64'h1122334455667788, 0, 0, lat, rd, er, h, p);
    mdl[2] = 64'h1122334455667788;
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL rw_wlat: got %0d want 2", lat); end
    n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL rw_werr: got %b want 0", er); end
    run_req(64'h10, 8'h00, {$urandom, $urandom}, 0, 0, lat, rd, er, h, p);
    n_cmp++; if (lat !== 2) begin n_bad++; $display("FAIL rw_rlat: got %0d want 2", lat); end
    n_cmp++; if (rd !== 64'h1122334455667788) begin n_bad++; $display("FAIL rw_rdata: got %h want 1122334455667788", rd); end
    n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL rw_rerr: got %b want 0", er); end
    n_cmp++; if (p !== 1'b1) begin n_bad++; $display("FAIL rw_idle_after: got %b want 1", p); end
  endtask

  task automatic test_partial;
    int lat; logic [63:0] rd; logic er; bit h, p;
    run_req(64'h10, 8'h0F, 64'hAAAAAAAABBBBBBBB, 0, 0, lat, rd, er, h, p);
    mdl[2] = merge(mdl[2], 64'hAAAAAAAABBBBBBBB, 8'h0F);
    n_cmp++; if (rd !== 64'h1122334455667788) begin n_bad++; $display("FAIL partial_old: got %h want 1122334455667788", rd); end
    run_req(64'h13, 8'h00, 64'h0, 0, 0, lat, rd, er, h, p);
    n_cmp++; if (rd !== 64'h11223344BBBBBBBB) begin n_bad++; $display("FAIL partial_new: got %h want 11223344bbbbbbbb", rd); end
  endtask

  task automatic test_oor;
    int lat; logic [63:0] rd, v; logic er; bit h, p;
    run_req(64'h2000, 8'h00, 64'h0, 0, 0, lat, rd, er, h, p);
    n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL oor_err: got %b want 1", er); end
    n_cmp++; if (rd !== 64'd0) begin n_bad++; $display("FAIL oor_rdata: got %h want 0", rd); end
    n_cmp++; if (lat !== LAT) begin n_bad++; $display("FAIL oor_lat: got %0d want %0d", lat, LAT); end
    run_req(64'h2000, 8'hFF, {$urandom, $urandom}, 0, 0, lat, rd, er, h, p);
    run_req(64'h8000000000000000, 8'hFF, {$urandom, $urandom}, 0, 0, lat, rd, er, h, p);
    n_cmp++; if (er !== 1'b1) begin n_bad++; $display("FAIL oor_top_err: got %b want 1", er); end
    run_req(64'h0, 8'h00, 64'h0, 0, 0, lat, rd, er, h, p);
    n_cmp++; if (rd !== mdl[0]) begin n_bad++; $display("FAIL oor_word0: got %h want %h", rd, mdl[0]); end
    v = {$urandom, $urandom};
    run_req(64'h1FF8, 8'hFF, v, 0, 0, lat, rd, er, h, p);
    n_cmp++; if (er !== 1'b0) begin n_bad++; $display("FAIL last_word_err: got %b want 0", er); end
    run_req(64'h1FFF, 8'h00, 64'h0, 0, 0, lat, rd, er, h, p);
    n_cmp++; if (rd !== v) begin n_bad++; $display("FAIL last_word_data: got %h want %h", rd, v); end
  endtask

  task automatic test_backpressure;
    int lat; logic [63:0] rd; logic er; bit h, p;
    run_req(64'h10, 8'h00, 64'h0, 5, 0, lat, rd, er, h, p);
    n_cmp++; if (h !== 1'b1) begin n_bad++; $display("FAIL bp_hold: got %b want 1", h); end
    n_cmp++; if (rd !== mdl[2]) begin n_bad++; $display("FAIL bp_rdata: got %h want %h", rd, mdl[2]); end
    n_cmp++; if (p !== 1'b1) begin n_bad++; $display("FAIL bp_release: got %b want 1", p); end
  endtask

  task automatic test_flush;
    int lat; logic [63:0] rd; logic er; bit h, p;
    run_req(64'h8, 8'hFF, 64'hDEAD, 0, 1, lat, rd, er, h, p);
    mdl[1] = 64'hDEAD;
    n_cmp++; if (p !== 1'b1) begin n_bad++; $display("FAIL flush_wait: got %b want 1", p); end
    run_req(64'h8, 8'h00, 64'h0, 0, 0, lat, rd, er, h, p);
    n_cmp++; if (rd !== 64'hDEAD) begin n_bad++; $display("FAIL flush_persist: got %h want dead", rd); end
    run_req(64'h18, 8'h00, 64'h0, 0, 2, lat, rd, er, h, p);
    n_cmp++; if (rd !== mdl[3]) begin n_bad++; $display("FAIL flush_resp_data: got %h want %h", rd, mdl[3]); end
    n_cmp++; if (p !== 1'b1) begin n_bad++; $display("FAIL flush_resp: got %b want 1", p); end
  endtask

  task automatic test_async_reset;
    int lat; logic [63:0] rd, v; logic er; bit h, p, quiet;
    v = {$urandom, $urandom};
    @(negedge clk);
    req_valid = 1'b1; req_addr = 64'h18; req_we = 8'hFF; req_wdata = v;
    @(posedge clk); #1;
    req_valid = 1'b0;
    mdl[3] = v;
    @(negedge clk); #2;
    rst = 1'b0; #1;
    n_cmp++; if (resp_rdata !== 64'd0) begin n_bad++; $display("FAIL arst_rdata: got %h want 0", resp_rdata); end
    @(negedge clk);
    rst = 1'b1; #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL arst_ready: got %b want 1", req_ready); end
    quiet = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (resp_valid !== 1'b0) quiet = 1'b0;
    end
    n_cmp++; if (quiet !== 1'b1) begin n_bad++; $display("FAIL arst_dropped: got %b want 1", quiet); end
    @(negedge clk);
    req_valid = 1'b1; req_addr = 64'h40000000; req_we = 8'h00;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    n_cmp++; if (resp_err !== 1'b1) begin n_bad++; $display("FAIL arst_err_pre: got %b want 1", resp_err); end
    #2; rst = 1'b0; #1;
    n_cmp++; if (resp_err !== 1'b0) begin n_bad++; $display("FAIL arst_err: got %b want 0", resp_err); end
    n_cmp++; if (resp_valid !== 1'b0) begin n_bad++; $display("FAIL arst_valid: got %b want 0", resp_valid); end
    @(negedge clk);
    rst = 1'b1; #1;
    n_cmp++; if (req_ready !== 1'b1) begin n_bad++; $display("FAIL arst_ready2: got %b want 1", req_ready); end
    run_req(64'h18, 8'h00, 64'h0, 0, 0, lat, rd, er, h, p);
    n_cmp++; if (rd !== v) begin n_bad++; $display("FAIL arst_persist: got %h want %h", rd, v); end
  endtask

  task automatic test_random;
    int lat, idx, stall, fmode; logic [63:0] a, wd, rd, erd; logic [7:0] we; logic er, eer, oor; bit h, p;
    for (int t = 0; t < 150; t++) begin
      idx   = $urandom_range(0, 15);
      oor   = ($urandom_range(0, 5) == 0);
      we    = ($urandom_range(0, 2) == 0) ? 8'h00 : 8'($urandom);
      wd    = {$urandom, $urandom};
      stall = $urandom_range(0, 3);
      fmode = ($urandom_range(0, 9) == 0) ? $urandom_range(1, 2) : 0;
      if (oor) begin
        a = {$urandom, $urandom};
        if (a[63:13] == '0) a[40] = 1'b1;
        erd = 64'd0; eer = 1'b1;
      end else begin
        a = (64'(idx) << 3) | 64'($urandom_range(0, 7));
        erd = mdl[idx]; eer = 1'b0;
        mdl[idx] = merge(mdl[idx], wd, we);
      end
      run_req(a, we, wd, stall, fmode, lat, rd, er, h, p);
      if (fmode == 1) begin
        n_cmp++; if (p !== 1'b1) begin n_bad++; $display("FAIL rnd_flush[%0d]: got %b want 1", t, p); end
      end else begin
        n_cmp++; if (lat !== LAT) begin n_bad++; $display("FAIL rnd_lat[%0d]: got %0d want %0d", t, lat, LAT); end
        n_cmp++; if (er !== eer) begin n_bad++; $display("FAIL rnd_err[%0d]: got %b want %b", t, er, eer); end
        if (oor || known[idx]) begin
          n_cmp++; if (rd !== erd) begin n_bad++; $display("FAIL rnd_rdata[%0d]: got %h want %h", t, rd, erd); end
        end
        n_cmp++; if (h !== 1'b1 || p !== 1'b1) begin n_bad++; $display("FAIL rnd_hs[%0d]: got hold=%b idle=%b want 1/1", t, h, p); end
      end
    end
  endtask

  initial begin
    rst = 1'b0; req_valid = 1'b0; req_addr = '0; req_we = '0; req_wdata = '0;
    req_flush = 1'b0; resp_ready = 1'b0;
    for (int i = 0; i < 16; i++) begin mdl[i] = '0; known[i] = 1'b0; end
    test_reset();
    test_init();
    test_rw();
    test_partial();
    test_oor();
    test_backpressure();
    test_flush();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
